// File: rtl/wresp_chan_slv.sv
// Target-side write response channel: queues write-completion events and
// replays them on the bvalid/bready response channel in completion order.
module wresp_chan_slv #(
    parameter int DEPTH    = 4,
    parameter int RESP_DLY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdone,
    input  logic [3:0] wdone_id,
    input  logic       wdone_ok,
    output logic       bvalid,
    input  logic       bready,
    output logic [3:0] bid,
    output logic       bcomp,
    output logic       q_full,
    output logic       ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [3:0]    DLY_C   = 4'(RESP_DLY);

    typedef enum logic [1:0] {
        RIDLE  = 2'b00,
        RDLY   = 2'b01,
        RVALID = 2'b10
    } state_e;

    typedef struct packed {
        logic [3:0] id;
        logic       ok;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head, next_head, wr_entry;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0] count_q, count_d;
    logic          q_full_q, q_full_d, ovf_err_q, ovf_err_d;
    logic          bvalid_q, bvalid_d, bcomp_q, bcomp_d;
    logic [3:0]    bid_q, bid_d, dly_cnt_q, dly_cnt_d;
    state_e        state_q, state_d;
    logic          push, pop;

    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bcomp   = bcomp_q;
    assign q_full  = q_full_q;
    assign ovf_err = ovf_err_q;

    assign wr_entry = '{id: wdone_id, ok: wdone_ok};

    // NOTE: storage array is deliberately not reset; the pointers and count
    // define which entries are valid, so clearing the data buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        pop       = bvalid_q & bready;
        push      = wdone & ((count_q != DEPTH_C) | pop);
        rd_nxt    = rd_ptr_q + AW'(1);
        head      = mem_q[rd_ptr_q];
        next_head = mem_q[rd_nxt];

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_nxt : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        q_full_d  = (count_d == DEPTH_C);
        ovf_err_d = ovf_err_q | (wdone & ~push);

        state_d   = state_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bcomp_d   = bcomp_q;
        dly_cnt_d = dly_cnt_q;

        case (state_q)
            RIDLE: begin
                if (count_q != '0) begin
                    if (DLY_C == 4'd0) begin
                        state_d  = RVALID;
                        bvalid_d = 1'b1;
                        bid_d    = head.id;
                        bcomp_d  = head.ok;
                    end else begin
                        state_d   = RDLY;
                        dly_cnt_d = DLY_C;
                    end
                end
            end
            RDLY: begin
                dly_cnt_d = dly_cnt_q - 4'd1;
                if (dly_cnt_q == 4'd1) begin
                    state_d  = RVALID;
                    bvalid_d = 1'b1;
                    bid_d    = head.id;
                    bcomp_d  = head.ok;
                end
            end
            RVALID: begin
                if (bready) begin
                    // Head is being popped; "more pending" means beyond the head.
                    if (count_q > ONE_C) begin
                        if (DLY_C == 4'd0) begin
                            bid_d   = next_head.id;
                            bcomp_d = next_head.ok;
                        end else begin
                            state_d   = RDLY;
                            bvalid_d  = 1'b0;
                            dly_cnt_d = DLY_C;
                        end
                    end else begin
                        state_d  = RIDLE;
                        bvalid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = RIDLE;
                bvalid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RIDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            q_full_q  <= 1'b0;
            ovf_err_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bcomp_q   <= 1'b0;
            dly_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            q_full_q  <= q_full_d;
            ovf_err_q <= ovf_err_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bcomp_q   <= bcomp_d;
            dly_cnt_q <= dly_cnt_d;
        end
    end

endmodule

// File: tb/tb_wresp_chan_slv.sv
// Directed bench for wresp_chan_slv: one instance with RESP_DLY=0 and one
// with RESP_DLY=3, both DEPTH=4, checked against hand-computed cycle timing.
module tb_wresp_chan_slv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wdone = 1'b0, wdone_ok = 1'b0, bready = 1'b0;
    logic [3:0] wdone_id = 4'd0;
    logic       bvalid, bcomp, q_full, ovf_err;
    logic [3:0] bid;

    logic       wdone3 = 1'b0, wdone_ok3 = 1'b0, bready3 = 1'b0;
    logic [3:0] wdone_id3 = 4'd0;
    logic       bvalid3, bcomp3, q_full3, ovf_err3;
    logic [3:0] bid3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wresp_chan_slv #(.DEPTH(4), .RESP_DLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wdone(wdone), .wdone_id(wdone_id),
        .wdone_ok(wdone_ok), .bvalid(bvalid), .bready(bready), .bid(bid),
        .bcomp(bcomp), .q_full(q_full), .ovf_err(ovf_err)
    );

    wresp_chan_slv #(.DEPTH(4), .RESP_DLY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wdone(wdone3), .wdone_id(wdone_id3),
        .wdone_ok(wdone_ok3), .bvalid(bvalid3), .bready(bready3), .bid(bid3),
        .bcomp(bcomp3), .q_full(q_full3), .ovf_err(ovf_err3)
    );

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_checks++; if (bvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_bvalid: got %b exp 0", bvalid); end
        n_checks++; if (bid !== 4'd0)     begin n_fail++; $display("FAIL reset_bid: got %h exp 0", bid); end
        n_checks++; if (bcomp !== 1'b0)   begin n_fail++; $display("FAIL reset_bcomp: got %b exp 0", bcomp); end
        n_checks++; if (q_full !== 1'b0)  begin n_fail++; $display("FAIL reset_q_full: got %b exp 0", q_full); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b exp 0", ovf_err); end
        n_checks++; if (bvalid3 !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid3: got %b exp 0", bvalid3); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        step();
        n_checks++; if (bvalid !== 1'b0)  begin n_fail++; $display("FAIL idle_bvalid: got %b exp 0", bvalid); end
    endtask

    task automatic test_single();
        int highs;
        bready = 1'b1;
        wdone = 1'b1; wdone_id = 4'h5; wdone_ok = 1'b1;
        step();
        wdone = 1'b0;
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL single_n1_bvalid: got %b exp 0", bvalid); end
        step();
        n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL single_n2_bvalid: got %b exp 1", bvalid); end
        n_checks++; if (bid !== 4'h5)    begin n_fail++; $display("FAIL single_bid: got %h exp 5", bid); end
        n_checks++; if (bcomp !== 1'b1)  begin n_fail++; $display("FAIL single_bcomp: got %b exp 1", bcomp); end
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bvalid === 1'b1) highs++;
        end
        n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL single_after_highs: got %0d exp 0", highs); end
        n_checks++; if (q_full !== 1'b0) begin n_fail++; $display("FAIL single_q_full: got %b exp 0", q_full); end
    endtask

    task automatic test_backpressure();
        int hs;
        int bad;
        bready = 1'b0;
        wdone = 1'b1; wdone_id = 4'h3; wdone_ok = 1'b0;
        step();
        wdone = 1'b0;
        step();
        bad = 0;
        hs  = 0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid !== 1'b1 || bid !== 4'h3 || bcomp !== 1'b0) bad++;
            if (bvalid === 1'b1 && bready === 1'b1) hs++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: %0d bad cycles, exp 0", bad); end
        bready = 1'b1;
        n_checks++; if (bvalid !== 1'b1 || bid !== 4'h3) begin n_fail++; $display("FAIL bp_release: bvalid %b bid %h exp 1/3", bvalid, bid); end
        for (int i = 0; i < 6; i++) begin
            if (bvalid === 1'b1 && bready === 1'b1) hs++;
            step();
        end
        n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d exp 1", hs); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_id;
        bready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wdone = 1'b1; wdone_id = 4'(i); wdone_ok = i[0];
            if (i == 4) begin
                n_checks++; if (q_full !== 1'b0) begin n_fail++; $display("FAIL ovf_q_full_early: got %b exp 0", q_full); end
            end
            if (i == 5) begin
                n_checks++; if (q_full !== 1'b1) begin n_fail++; $display("FAIL ovf_q_full_after4: got %b exp 1", q_full); end
                n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early: got %b exp 0", ovf_err); end
            end
            step();
        end
        wdone = 1'b0;
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %b exp 1", ovf_err); end
        n_checks++; if (q_full !== 1'b1)  begin n_fail++; $display("FAIL ovf_q_full_hold: got %b exp 1", q_full); end
        step();
        bready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_id = 4'(i);
            n_checks++;
            if (bvalid !== 1'b1 || bid !== exp_id || bcomp !== exp_id[0]) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: bvalid %b bid %h bcomp %b exp 1/%h/%b", i, bvalid, bid, bcomp, exp_id, exp_id[0]);
            end
            step();
            if (i == 1) begin
                n_checks++; if (q_full !== 1'b0) begin n_fail++; $display("FAIL ovf_q_full_fall: got %b exp 0", q_full); end
            end
        end
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: bvalid %b exp 0 (id 5 must be dropped)", bvalid); end
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b exp 1", ovf_err); end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] exp_ids [4];
        exp_ids[0] = 4'hB; exp_ids[1] = 4'hC; exp_ids[2] = 4'hD; exp_ids[3] = 4'h9;
        do_reset();
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdone = 1'b1; wdone_id = 4'(10 + i); wdone_ok = 1'b0;
            step();
        end
        wdone = 1'b0;
        step();
        n_checks++; if (q_full !== 1'b1 || bvalid !== 1'b1 || bid !== 4'hA) begin n_fail++; $display("FAIL ppf_full: q_full %b bvalid %b bid %h exp 1/1/a", q_full, bvalid, bid); end
        bready = 1'b1;
        wdone = 1'b1; wdone_id = 4'h9; wdone_ok = 1'b1;
        step();
        wdone = 1'b0;
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ppf_ovf_err: got %b exp 0", ovf_err); end
        n_checks++; if (q_full !== 1'b1)  begin n_fail++; $display("FAIL ppf_count_held: q_full %b exp 1", q_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bid !== exp_ids[i] || bcomp !== (i == 3)) begin
                n_fail++;
                $display("FAIL ppf_order_%0d: bvalid %b bid %h bcomp %b exp 1/%h/%b", i, bvalid, bid, bcomp, exp_ids[i], (i == 3));
            end
            step();
        end
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL ppf_empty: bvalid %b exp 0", bvalid); end
    endtask

    task automatic test_resp_dly();
        logic exp_v [11];
        for (int i = 0; i < 11; i++) exp_v[i] = (i == 5 || i == 9);
        bready3 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wdone3    = (i < 2);
            wdone_id3 = (i == 0) ? 4'h7 : 4'h8;
            wdone_ok3 = (i == 0);
            n_checks++;
            if (bvalid3 !== exp_v[i]) begin n_fail++; $display("FAIL dly_bvalid_n%0d: got %b exp %b", i, bvalid3, exp_v[i]); end
            if (i == 5) begin
                n_checks++; if (bid3 !== 4'h7 || bcomp3 !== 1'b1) begin n_fail++; $display("FAIL dly_first: bid %h bcomp %b exp 7/1", bid3, bcomp3); end
            end
            if (i == 9) begin
                n_checks++; if (bid3 !== 4'h8 || bcomp3 !== 1'b0) begin n_fail++; $display("FAIL dly_second: bid %h bcomp %b exp 8/0", bid3, bcomp3); end
            end
            step();
        end
        wdone3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int highs;
        bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdone = 1'b1; wdone_id = 4'(2 * i + 2); wdone_ok = 1'b1;
            step();
        end
        wdone = 1'b0;
        n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_bvalid: got %b exp 1", bvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_drop: got %b exp 0", bvalid); end
        n_checks++; if (bid !== 4'd0)    begin n_fail++; $display("FAIL rmid_bid: got %h exp 0", bid); end
        #2 rst_n = 1'b1;
        bready = 1'b1;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bvalid === 1'b1) highs++;
        end
        n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL rmid_no_stale: %0d bvalid cycles exp 0", highs); end
        wdone = 1'b1; wdone_id = 4'hE; wdone_ok = 1'b1;
        step();
        wdone = 1'b0;
        step();
        n_checks++; if (bvalid !== 1'b1 || bid !== 4'hE) begin n_fail++; $display("FAIL rmid_new: bvalid %b bid %h exp 1/e", bvalid, bid); end
        step();
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_end: bvalid %b exp 0", bvalid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_push_pop_full();
        test_resp_dly();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wresp_chan_slv.md
Name: wresp_chan_slv

Overview:
- Target-side write response channel generator; counterpart to the initiator's response channel manager.
- Queues write-completion events from the target's write data path, each carrying an ID and a completion flag.
- Drives bvalid/bid/bcomp to the bus under a valid/ready handshake, one response per completed write, in completion order.
- Sits between the target write data channel logic and the bus response channel.

Parameters:
DEPTH, 4, response queue entries; power of two, minimum 2
RESP_DLY, 0, extra idle cycles inserted before each bvalid assertion (0..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wdone  input  1  one-cycle pulse: a write burst finished on the target side
wdone_id  input  4  ID of the finished write
wdone_ok  input  1  completion status of the finished write; becomes bcomp
bvalid  output  1  response valid
bready  input  1  response accepted by the initiator
bid  output  4  response ID
bcomp  output  1  response completion flag
q_full  output  1  queue holds DEPTH entries
ovf_err  output  1  sticky: a wdone was dropped

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low.
  - Reset values: bvalid=0, bid=0, bcomp=0, q_full=0, ovf_err=0.
  - Queue emptied; FSM goes to RIDLE; delay counter cleared.
  - Reset mid-response drops bvalid immediately and discards all pending entries.
- Queue:
  - Circular FIFO of {id[3:0], ok}, DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - q_full = (count == DEPTH), registered.
- Push and pop:
  - Push on wdone when count<DEPTH, or when a pop occurs in the same cycle (simultaneous push+pop at full is accepted; count unchanged).
  - wdone at full with no pop: entry dropped, ovf_err set to 1; cleared only by reset.
  - Pop on bvalid & bready.
  - Simultaneous push and pop at any count: count unchanged, both pointers advance.
- FSM, 2-bit state:
  - RIDLE (bvalid=0):
    - If count!=0 and RESP_DLY==0: go to RVALID, loading bid/bcomp from the queue head at the same edge.
    - If count!=0 and RESP_DLY>0: go to RDLY, loading the counter with RESP_DLY.
  - RDLY (bvalid=0):
    - Counter decrements every cycle.
    - When the counter reaches 1: go to RVALID, loading head into bid/bcomp.
    - RDLY lasts exactly RESP_DLY cycles.
  - RVALID (bvalid=1):
    - bid/bcomp held stable while bready=0.
    - On bready with more entries pending beyond the head and RESP_DLY==0: stay in RVALID and load the next entry, giving back-to-back responses.
    - On bready with more entries pending and RESP_DLY>0: go to RDLY.
    - On bready with no entries pending: go to RIDLE.
  - Unused encoding: go to RIDLE.
- Latency: wdone in cycle N into an empty queue gives bvalid high from cycle N+2+RESP_DLY.
- Handshake rules:
  - Once bvalid is asserted it never deasserts before bready.
  - bvalid is never asserted while the queue is empty.
  - bvalid never depends combinationally on bready.
- bid/bcomp hold their last value while bvalid=0.
- Ordering: responses are emitted strictly in wdone order, regardless of ID.

Test Plan:
- Single write, RESP_DLY=0:
  - Stimulus: wdone, id=4'h5, ok=1 in cycle 10; bready tied 1.
  - Required: bvalid=1 in cycle 12 only, bid=5, bcomp=1; queue empty afterwards.
- Back-pressure:
  - Stimulus: id=3, ok=0; bready held 0 for 6 cycles, then 1.
  - Required: bvalid stays 1 throughout with bid=3, bcomp=0 stable; exactly one handshake.
- Burst and overflow, DEPTH=4:
  - Stimulus: 5 consecutive wdone (ids 1..5) with bready=0.
  - Required: q_full=1 after the 4th; the 5th is dropped and ovf_err=1.
  - Then bready=1: responses ids 1,2,3,4 on four consecutive cycles; q_full falls after the first pop.
- Simultaneous push and pop at full:
  - Stimulus: queue full, wdone id=9 in the same cycle as a handshake.
  - Required: entry accepted, ovf_err stays 0, count stays 4; id 9 emitted last.
- RESP_DLY=3:
  - Stimulus: two queued entries (ids 7, 8), bready=1.
  - Required: bvalid for id 7 at N+5; bvalid for id 8 exactly 3 idle cycles after the first handshake.
- Reset mid-operation:
  - Stimulus: rst_n low while bvalid=1 with 3 entries queued.
  - Required: bvalid=0 asynchronously; after release no response appears until a new wdone.
